ffn_tile_sequencer: RTL and testbench
=====================================

// Module: ffn_tile_sequencer
// PURPOSE
// - Top-level sequencer for the FFN matrix-vector datapath: walks NUM_TILES output tiles.
// - For each tile: clears the accumulator and issues feature-map addresses 0..ADDR_MAX while
//   the input buffer is ready. It then drains the multiplier pipeline and hands the tile
//   result downstream with a valid/ready handshake.
// - Sits between the layer controller (start/done) and the FFN multiply/accumulate array.
// PARAMETERS
// - ADDR_WIDTH  `FM_ADDR_WIDTH  width of feature-map/weight address bus
// - ADDR_MAX    `ADDR_MAX       last address of one tile pass (pass length ADDR_MAX+1)
// - NUM_TILES   4               output tiles per layer run (>=1)
// - TILE_BITS   2               width of tile index, clog2(NUM_TILES), min 1
// - PIPE_LAT    3               multiplier+adder latency after last address (>=1)
// PORTS
// - clock       in   1           rising-edge clock
// - reset       in   1           asynchronous, active-low reset
// - start       in   1           begin a layer run; sampled only in IDLE
// - buffer_rdy  in   1           input buffer holds valid data this cycle
// - out_ready   in   1           downstream accepts tile result
// - addr        out  ADDR_WIDTH  feature-map/weight address
// - addr_valid  out  1           addr is issued to datapath this cycle
// - acc_clear   out  1           zero accumulator (held in LOAD)
// - tile_idx    out  TILE_BITS   current tile number
// - out_valid   out  1           tile result valid at accumulator output
// - busy        out  1           high in every state except IDLE
// - done        out  1           one-cycle pulse after the last tile handshake
// BEHAVIOUR
// - Reset (asynchronous): state=IDLE; addr=0, tile_idx=0; all 1-bit outputs=0.
//   Reset mid-run aborts the run; no done is generated.
// - All outputs are registered.
// - FSM states: IDLE, LOAD, RUN, DRAIN, WRITE, FIN.
// - IDLE: start=1 -> LOAD, tile_idx=0.
// - LOAD: acc_clear=1, addr=0. If buffer_rdy=1 -> RUN, else stay.
// - RUN: each cycle with buffer_rdy=1, addr_valid=1 and addr increments by 1.
//   - Stall: buffer_rdy=0 -> addr holds and addr_valid=0. No address is skipped or repeated.
//   - When addr==ADDR_MAX is issued: addr wraps to 0 and the FSM goes to DRAIN.
//   - Unstalled, addr_valid is high for exactly ADDR_MAX+1 cycles per tile.
// - DRAIN: down-counter loaded with PIPE_LAT-1 on entry. At zero -> WRITE.
// - WRITE: out_valid=1 until out_valid&&out_ready.
//   - On handshake: if tile_idx==NUM_TILES-1 -> FIN; else tile_idx+1 -> LOAD.
// - FIN: done=1 for one cycle, tile_idx resets to 0 -> IDLE.
// - start is ignored when busy=1, including start coincident with done.
// - Address arithmetic is modulo 2^ADDR_WIDTH. ADDR_MAX < 2^ADDR_WIDTH is required
//   (elaboration check).
// - out_valid, once asserted, stays high with tile_idx stable until accepted.
// STRUCTURE
// - Shared package/header (network_params.h): FM_ADDR_WIDTH, ADDR_MAX, FSM state encodings
//   (localparam, 3-bit), NUM_TILES default.
// - One sub-module, ffn_addr_gen: the stallable address counter.
//   - Inputs: clear, enable.
//   - Outputs: addr, last (addr==ADDR_MAX).
// - FSM, drain counter and tile counter stay in this module.
// TESTING  (ADDR_MAX=7, NUM_TILES=3, PIPE_LAT=2)
// - Nominal run: start pulse, buffer_rdy=1, out_ready=1.
//   -> per tile: addr 0..7 with addr_valid, 8 cycles contiguous.
//   -> out_valid appears 2 cycles after addr 7 is issued.
//   -> tile_idx 0,1,2; done pulses once; busy falls with FSM return to IDLE.
// - Stall: buffer_rdy low for 3 cycles while addr==4.
//   -> addr holds 4, addr_valid=0; resumes 4,5,6,7 with no duplicates.
// - Backpressure: out_ready=0 for 5 cycles in WRITE.
//   -> out_valid and tile_idx stable; the next tile's LOAD does not begin until the handshake.
// - Start while busy: start pulses during RUN and again in the done cycle.
//   -> both ignored; exactly one done for the run.
// - Reset mid-RUN: reset low at addr=5 of tile 1.
//   -> all outputs 0 asynchronously; a new start runs tiles 0..2 cleanly.
// - NUM_TILES=1, PIPE_LAT=1: single tile.
//   -> out_valid 1 cycle after addr 7; done after the first handshake.

Source files
------------

// File: rtl/ffn_tile_sequencer_pkg.sv
// rtl/ffn_tile_sequencer_pkg.sv - shared parameters and FSM state encoding for the FFN tile sequencer
package ffn_tile_sequencer_pkg;

    localparam int FM_ADDR_WIDTH     = 4;
    localparam int FM_ADDR_MAX       = 7;
    localparam int NUM_TILES_DEFAULT = 4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_WRITE = 3'd4,
        S_FIN   = 3'd5
    } state_e;

endpackage

// File: rtl/ffn_addr_gen.sv
// rtl/ffn_addr_gen.sv - stallable feature-map address counter with end-of-pass flag
module ffn_addr_gen
    import ffn_tile_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH = FM_ADDR_WIDTH,
    parameter int ADDR_MAX   = FM_ADDR_MAX
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  enable_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  last_o
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(ADDR_MAX);

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    // clear wins over enable so the final issue of a pass wraps straight to zero
    always_comb begin
        addr_d = addr_q;
        if (clear_i) begin
            addr_d = '0;
        end else if (enable_i) begin
            addr_d = addr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr_o = addr_q;
    assign last_o = (addr_q == LAST_ADDR);

endmodule

// File: rtl/ffn_tile_sequencer.sv
// rtl/ffn_tile_sequencer.sv - walks output tiles: clear, address pass, pipeline drain, result handshake
module ffn_tile_sequencer
    import ffn_tile_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH = FM_ADDR_WIDTH,
    parameter int ADDR_MAX   = FM_ADDR_MAX,
    parameter int NUM_TILES  = NUM_TILES_DEFAULT,
    parameter int TILE_BITS  = 2,
    parameter int PIPE_LAT   = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic                  buffer_rdy_i,
    input  logic                  out_ready_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  addr_valid_o,
    output logic                  acc_clear_o,
    output logic [TILE_BITS-1:0]  tile_idx_o,
    output logic                  out_valid_o,
    output logic                  busy_o,
    output logic                  done_o
);

    if (ADDR_MAX >= (1 << ADDR_WIDTH)) begin : g_bad_addr_max
        $error("ADDR_MAX does not fit in ADDR_WIDTH");
    end
    if (NUM_TILES < 1 || PIPE_LAT < 1) begin : g_bad_counts
        $error("NUM_TILES and PIPE_LAT must be at least 1");
    end

    localparam int                   DW         = $clog2(PIPE_LAT) + 1;
    localparam logic [DW-1:0]        DRAIN_LOAD = DW'(PIPE_LAT - 1);
    localparam logic [TILE_BITS-1:0] LAST_TILE  = TILE_BITS'(NUM_TILES - 1);

    state_e                state_q, state_d;
    logic [DW-1:0]         drain_q, drain_d;
    logic [TILE_BITS-1:0]  tile_q, tile_d;
    logic                  addr_valid_q, addr_valid_d;
    logic                  acc_clear_q, acc_clear_d;
    logic                  out_valid_q, out_valid_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  ag_clear, ag_enable, ag_last, issue_last;

    // an address is issued in any RUN cycle whose registered addr_valid is high
    assign ag_enable  = (state_q == S_RUN) && addr_valid_q;
    assign issue_last = ag_enable && ag_last;
    assign ag_clear   = (state_q == S_LOAD) || issue_last;

    ffn_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .ADDR_MAX   (ADDR_MAX)
    ) u_addr_gen (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (ag_clear),
        .enable_i (ag_enable),
        .addr_o   (addr_o),
        .last_o   (ag_last)
    );

    always_comb begin
        state_d      = state_q;
        drain_d      = drain_q;
        tile_d       = tile_q;
        addr_valid_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_LOAD;
                    tile_d  = '0;
                end
            end
            S_LOAD: begin
                if (buffer_rdy_i) begin
                    state_d      = S_RUN;
                    addr_valid_d = 1'b1;
                end
            end
            S_RUN: begin
                if (issue_last) begin
                    drain_d = DRAIN_LOAD;
                    state_d = (PIPE_LAT > 1) ? S_DRAIN : S_WRITE;
                end else begin
                    addr_valid_d = buffer_rdy_i;
                end
            end
            // DRAIN spans PIPE_LAT-1 cycles so out_valid rises PIPE_LAT cycles after the last issue
            S_DRAIN: begin
                drain_d = drain_q - DW'(1);
                if (drain_q <= DW'(1)) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (out_valid_q && out_ready_i) begin
                    if (tile_q == LAST_TILE) begin
                        state_d = S_FIN;
                    end else begin
                        tile_d  = tile_q + 1'b1;
                        state_d = S_LOAD;
                    end
                end
            end
            S_FIN: begin
                tile_d  = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        acc_clear_d = (state_d == S_LOAD);
        out_valid_d = (state_d == S_WRITE);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_FIN);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            drain_q      <= '0;
            tile_q       <= '0;
            addr_valid_q <= 1'b0;
            acc_clear_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            drain_q      <= drain_d;
            tile_q       <= tile_d;
            addr_valid_q <= addr_valid_d;
            acc_clear_q  <= acc_clear_d;
            out_valid_q  <= out_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign addr_valid_o = addr_valid_q;
    assign acc_clear_o  = acc_clear_q;
    assign tile_idx_o   = tile_q;
    assign out_valid_o  = out_valid_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_ffn_tile_sequencer.sv
// tb/tb_ffn_tile_sequencer.sv - self-checking bench for ffn_tile_sequencer
module tb_ffn_tile_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, rdy, ordy;
    logic [3:0] addr;
    logic       av, clr, ov, busy, done;
    logic [1:0] tile;
    logic       start1, rdy1, ordy1;
    logic [3:0] addr1;
    logic       av1, clr1, ov1, busy1, done1;
    logic [0:0] tile1;

    int checks = 0;
    int errors = 0;
    int n_valid, n_done, a7, ov_c, done_c;
    int tile_log[$];

    always #5 clk = ~clk;

    ffn_tile_sequencer #(
        .ADDR_WIDTH(4), .ADDR_MAX(7), .NUM_TILES(3), .TILE_BITS(2), .PIPE_LAT(2)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .buffer_rdy_i(rdy), .out_ready_i(ordy),
        .addr_o(addr), .addr_valid_o(av), .acc_clear_o(clr), .tile_idx_o(tile),
        .out_valid_o(ov), .busy_o(busy), .done_o(done)
    );

    ffn_tile_sequencer #(
        .ADDR_WIDTH(4), .ADDR_MAX(7), .NUM_TILES(1), .TILE_BITS(1), .PIPE_LAT(1)
    ) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start1), .buffer_rdy_i(rdy1), .out_ready_i(ordy1),
        .addr_o(addr1), .addr_valid_o(av1), .acc_clear_o(clr1), .tile_idx_o(tile1),
        .out_valid_o(ov1), .busy_o(busy1), .done_o(done1)
    );

    typedef struct {
        logic       start;
        logic       rdy;
        logic       ordy;
        logic [3:0] addr;
        logic       av;
        logic       clr;
        logic [1:0] tile;
        logic       ov;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic s, r, o, input logic [3:0] a, input logic v, c,
                       input logic [1:0] t, input logic ov_e, b, d);
        vec_t x;
        x.start = s; x.rdy = r; x.ordy = o; x.addr = a; x.av = v; x.clr = c;
        x.tile = t; x.ov = ov_e; x.busy = b; x.done = d;
        vecs.push_back(x);
    endtask

    function automatic logic [10:0] pack(input vec_t v);
        return {v.addr, v.av, v.clr, v.tile, v.ov, v.busy, v.done};
    endfunction

    function automatic logic [10:0] outs();
        return {addr, av, clr, tile, ov, busy, done};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step(input logic s, r, o);
        @(negedge clk);
        start = s; rdy = r; ordy = o;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        start = 0; rdy = 0; ordy = 0; start1 = 0; rdy1 = 0; ordy1 = 0; rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", 32'(outs()), 32'd0);
        chk("reset_state_single", 32'({addr1, av1, clr1, tile1, ov1, busy1, done1}), 32'd0);
        @(negedge clk);
        rst_n = 1;

        // nominal three-tile run; start re-pulsed mid-RUN and in the done cycle
        add(1, 1, 1, 4'd0, 0, 1, 2'd0, 0, 1, 0);
        for (int t = 0; t < 3; t++) begin
            for (int k = 0; k < 8; k++)
                add(t == 0 && k == 3, 1, 1, 4'(k), 1, 0, 2'(t), 0, 1, 0);
            add(0, 1, 1, 4'd0, 0, 0, 2'(t), 0, 1, 0);
            add(0, 1, 1, 4'd0, 0, 0, 2'(t), 1, 1, 0);
            if (t < 2) add(0, 1, 1, 4'd0, 0, 1, 2'(t + 1), 0, 1, 0);
            else       add(0, 1, 1, 4'd0, 0, 0, 2'd2, 0, 1, 1);
        end
        add(1, 1, 1, 4'd0, 0, 0, 2'd0, 0, 0, 0);
        add(0, 1, 1, 4'd0, 0, 0, 2'd0, 0, 0, 0);

        foreach (vecs[i]) begin
            step(vecs[i].start, vecs[i].rdy, vecs[i].ordy);
            chk($sformatf("vec%0d", i), 32'(outs()), 32'(pack(vecs[i])));
        end

        // stall at addr 4, then backpressure in WRITE
        step(1, 1, 1);
        for (int k = 0; k < 4; k++) begin
            step(0, 1, 1);
            chk($sformatf("pre_stall_addr%0d", k), 32'({addr, av}), 32'({4'(k), 1'b1}));
        end
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 1);
            chk("stall_hold", 32'({addr, av}), 32'({4'd4, 1'b0}));
        end
        for (int k = 4; k < 8; k++) begin
            step(0, 1, 1);
            chk($sformatf("resume_addr%0d", k), 32'({addr, av}), 32'({4'(k), 1'b1}));
        end
        step(0, 1, 0);
        step(0, 1, 0);
        chk("bp_write_entry", 32'({ov, tile}), 32'({1'b1, 2'd0}));
        for (int k = 0; k < 5; k++) begin
            step(0, 1, 0);
            chk("bp_hold", 32'({ov, tile, clr, busy}), 32'({1'b1, 2'd0, 1'b0, 1'b1}));
        end
        step(0, 1, 1);
        chk("bp_release_load", 32'({ov, tile, clr}), 32'({1'b0, 2'd1, 1'b1}));

        // asynchronous reset at addr 5 of tile 1
        for (int k = 0; k < 6; k++) step(0, 1, 1);
        chk("pre_reset_addr5", 32'({addr, av, tile}), 32'({4'd5, 1'b1, 2'd1}));
        #2 rst_n = 0;
        #1 chk("async_reset", 32'(outs()), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;

        // clean rerun after reset
        step(1, 1, 1);
        n_valid = 0; n_done = 0;
        for (int c = 0; c < 200; c++) begin
            step(0, 1, 1);
            if (av) n_valid++;
            if (ov) tile_log.push_back(int'(tile));
            if (done) n_done++;
            if (!busy) break;
        end
        chk("rerun_idle", 32'(busy), 32'd0);
        chk("rerun_issue_count", 32'(n_valid), 32'd24);
        chk("rerun_done_count", 32'(n_done), 32'd1);
        chk("rerun_tile_count", 32'(tile_log.size()), 32'd3);
        foreach (tile_log[i]) chk($sformatf("rerun_tile%0d", i), 32'(tile_log[i]), 32'(i));

        // single tile, PIPE_LAT=1
        a7 = -1; ov_c = -1; done_c = -1; n_done = 0;
        @(negedge clk);
        start1 = 1; rdy1 = 1; ordy1 = 1;
        @(negedge clk);
        start1 = 0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk);
            #1;
            if (av1 && addr1 == 4'd7) a7 = c;
            if (ov1 && ov_c < 0) ov_c = c;
            if (done1) begin
                done_c = c;
                n_done++;
            end
            if (!busy1) break;
        end
        chk("single_ov_latency", 32'(ov_c), 32'(a7 + 1));
        chk("single_done_after_hs", 32'(done_c), 32'(ov_c + 1));
        chk("single_done_count", 32'(n_done), 32'd1);
        chk("single_idle", 32'(busy1), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
